// File: rtl/seg_display_decoder.sv
// Receive side of a two-digit multiplexed 7-segment display bus.
// Samples the scanned segment/anode lines and recovers tens, units and the binary value.
module seg_display_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned MATCH_FRAMES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       an3_in,
    input  logic       an4_in,
    output logic [3:0] value_out,
    output logic [3:0] tens_out,
    output logic [3:0] units_out,
    output logic       valid,
    output logic       frame_done,
    output logic       err_seg,
    output logic       err_range
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MATCH_W  = $clog2(MATCH_FRAMES + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LATCH,
        S_WAIT,
        S_FRAME
    } state_t;

    state_t state, next_state;

    logic [6:0]          seg_q;
    logic                an3_q, an4_q;
    logic                cur_id;        // 0 = tens slot, 1 = units slot
    logic [6:0]          cur_seg;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [3:0]          tens_slot, units_slot;
    logic                tens_flag, units_flag;
    logic [3:0]          prev_tens, prev_units;
    logic                prev_ok;
    logic [MATCH_W-1:0]  match_cnt;
    logic                upd_pending;
    logic [TO_W-1:0]     to_cnt;

    logic                active_c, id_c, to_hit_c;
    logic                load_cur_c, settle_inc_c, latch_en_c, frame_en_c;
    logic [4:0]          dec_c;
    logic [6:0]          value_c;

    // Active-low decode; blank is legal only on the tens digit.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg, input logic is_tens);
        logic [4:0] r;
        r = {1'b1, 4'd0};
        case (seg)
            7'b0000001: r = {1'b0, 4'd0};
            7'b1001111: r = {1'b0, 4'd1};
            7'b0010010: r = {1'b0, 4'd2};
            7'b0000110: r = {1'b0, 4'd3};
            7'b1001100: r = {1'b0, 4'd4};
            7'b0100100: r = {1'b0, 4'd5};
            7'b0100000: r = {1'b0, 4'd6};
            7'b0001111: r = {1'b0, 4'd7};
            7'b0000000: r = {1'b0, 4'd8};
            7'b0000100: r = {1'b0, 4'd9};
            7'b1111111: r = {~is_tens, 4'd0};
            default:    r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    assign active_c = an3_q ^ an4_q;
    assign id_c     = an3_q;   // an3 high while active means an4 is driving
    assign dec_c    = decode_seg(cur_seg, ~cur_id);
    assign to_hit_c = (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign value_c  = 7'(prev_tens) * 7'd10 + 7'(prev_units);

    // Input sample stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 7'h7F;
            an3_q <= 1'b1;
            an4_q <= 1'b1;
        end else begin
            seg_q <= seg_in;
            an3_q <= an3_in;
            an4_q <= an4_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state and datapath strobes.
    always_comb begin
        next_state   = state;
        load_cur_c   = 1'b0;
        settle_inc_c = 1'b0;
        latch_en_c   = 1'b0;
        frame_en_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (active_c) begin
                    load_cur_c = 1'b1;
                    next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!active_c) begin
                    next_state = S_IDLE;
                end else if (id_c != cur_id || seg_q != cur_seg) begin
                    load_cur_c = 1'b1;
                end else begin
                    settle_inc_c = 1'b1;
                    if (settle_cnt >= SETTLE_W'(SETTLE_CYCLES - 1)) next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                latch_en_c = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (!active_c || id_c != cur_id)
                    next_state = (tens_flag && units_flag) ? S_FRAME : S_IDLE;
            end
            S_FRAME: begin
                frame_en_c = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Digit capture, frame matching, timeout and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id      <= 1'b0;
            cur_seg     <= 7'h7F;
            settle_cnt  <= '0;
            tens_slot   <= '0;
            units_slot  <= '0;
            tens_flag   <= 1'b0;
            units_flag  <= 1'b0;
            prev_tens   <= '0;
            prev_units  <= '0;
            prev_ok     <= 1'b0;
            match_cnt   <= '0;
            upd_pending <= 1'b0;
            to_cnt      <= '0;
            value_out   <= '0;
            tens_out    <= '0;
            units_out   <= '0;
            valid       <= 1'b0;
            frame_done  <= 1'b0;
            err_seg     <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            if (load_cur_c) begin
                cur_id     <= id_c;
                cur_seg    <= seg_q;
                settle_cnt <= SETTLE_W'(1);
            end else if (settle_inc_c) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end

            if (latch_en_c) begin
                if (cur_id) begin
                    units_slot <= dec_c[3:0];
                    units_flag <= 1'b1;
                end else begin
                    tens_slot <= dec_c[3:0];
                    tens_flag <= 1'b1;
                end
                if (dec_c[4]) err_seg <= 1'b1;
            end

            frame_done  <= frame_en_c;
            upd_pending <= frame_en_c;

            // Timeout saturates and keeps valid/match cleared until a frame arrives.
            if (to_hit_c) begin
                valid     <= 1'b0;
                match_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (frame_en_c) begin
                to_cnt     <= '0;
                tens_flag  <= 1'b0;
                units_flag <= 1'b0;
                if (prev_ok && tens_slot == prev_tens && units_slot == prev_units)
                    match_cnt <= (match_cnt >= MATCH_W'(MATCH_FRAMES)) ? match_cnt
                                                                      : match_cnt + MATCH_W'(1);
                else
                    match_cnt <= MATCH_W'(1);
                prev_tens  <= tens_slot;
                prev_units <= units_slot;
                prev_ok    <= 1'b1;
            end

            // Publish a confirmed frame the cycle after it was assembled.
            if (upd_pending && match_cnt >= MATCH_W'(MATCH_FRAMES)) begin
                if (value_c <= 7'd15) begin
                    tens_out  <= prev_tens;
                    units_out <= prev_units;
                    value_out <= value_c[3:0];
                    valid     <= 1'b1;
                end else begin
                    valid     <= 1'b0;
                    err_range <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Scoreboard bench for seg_display_decoder with a frame-level reference model.
`timescale 1ns/1ps
module tb_seg_display_decoder;

    localparam logic [6:0] BLANK = 7'h7F;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       an3_in, an4_in;
    logic [3:0] value_out, tens_out, units_out;
    logic       valid, frame_done, err_seg, err_range;

    seg_display_decoder dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an3_in(an3_in), .an4_in(an4_in),
        .value_out(value_out), .tens_out(tens_out), .units_out(units_out),
        .valid(valid), .frame_done(frame_done), .err_seg(err_seg), .err_range(err_range)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] t;
        logic [3:0] u;
        logic       valid;
        logic       es;
        logic       er;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   frames_seen = 0;

    // Reference model state: what the display "should" be showing.
    int m_v, m_t, m_u, prev_t, prev_u, match;
    bit m_valid, m_es, m_er, prev_ok;

    function automatic logic [6:0] pat_of(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    task automatic decode(input logic [6:0] p, input bit is_tens, output int d, output bit e);
        d = 0;
        e = 1'b1;
        for (int i = 0; i < 10; i++) if (pat_of(i) == p) begin d = i; e = 1'b0; end
        if (p == BLANK && is_tens) e = 1'b0;
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.v = 4'(m_v); e.t = 4'(m_t); e.u = 4'(m_u);
        e.valid = m_valid; e.es = m_es; e.er = m_er;
        return e;
    endfunction

    function automatic exp_t dut_now();
        exp_t g;
        g.v = value_out; g.t = tens_out; g.u = units_out;
        g.valid = valid; g.es = err_seg; g.er = err_range;
        return g;
    endfunction

    task automatic model_reset();
        m_v = 0; m_t = 0; m_u = 0; m_valid = 0; m_es = 0; m_er = 0;
        prev_t = 0; prev_u = 0; prev_ok = 0; match = 0;
    endtask

    // One completed frame: count consecutive repeats, publish once seen twice.
    task automatic model_frame(input logic [6:0] pt, input logic [6:0] pu);
        int dt, du, val;
        bit e;
        decode(pt, 1'b1, dt, e); if (e) m_es = 1;
        decode(pu, 1'b0, du, e); if (e) m_es = 1;
        if (prev_ok && dt == prev_t && du == prev_u) match++;
        else match = 1;
        prev_t = dt; prev_u = du; prev_ok = 1;
        if (match >= 2) begin
            val = dt * 10 + du;
            if (val <= 15) begin
                m_t = dt; m_u = du; m_v = val; m_valid = 1;
            end else begin
                m_valid = 0; m_er = 1;
            end
        end
        exp_q.push_back(model_now());
    endtask

    task automatic check_state(input string name, input exp_t e);
        exp_t g;
        g = dut_now();
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got v=%0d t=%0d u=%0d valid=%0d es=%0d er=%0d, want v=%0d t=%0d u=%0d valid=%0d es=%0d er=%0d",
                     name, g.v, g.t, g.u, g.valid, g.es, g.er, e.v, e.t, e.u, e.valid, e.es, e.er);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0b, want %0b", name, got, want);
        end
    endtask

    task automatic drive(input logic a3, input logic a4, input logic [6:0] s, input int n);
        an3_in = a3; an4_in = a4; seg_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [6:0] pt, input logic [6:0] pu, input int nt, input int nu);
        model_frame(pt, pu);
        drive(1'b0, 1'b1, pt, nt);
        drive(1'b1, 1'b0, pu, nu);
        drive(1'b1, 1'b1, BLANK, 8);
    endtask

    // Monitor: each frame_done pops one expectation and compares once outputs settle.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                frames_seen++;
                @(negedge clk);
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL frame_unexpected: got frame_done with empty queue, want none");
                end else begin
                    check_state("frame", exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, want finish before 5 ms");
        $fatal(1, "watchdog");
    end

    logic [6:0] bad_pats [4] = '{7'h55, 7'h2A, 7'h7E, 7'h3F};

    initial begin
        int fc, reps, waited;
        logic [6:0] pt, pu;
        rst = 1'b1; an3_in = 1'b1; an4_in = 1'b1; seg_in = BLANK;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset_outputs", model_now());
        check_bit("reset_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, BLANK, 4);

        // Steady 11.
        repeat (3) send_frame(pat_of(1), pat_of(1), 50, 50);
        // Blank tens, units 7.
        repeat (3) send_frame(BLANK, pat_of(7), 50, 50);

        // Units digit too short to settle: no frame, nothing changes.
        fc = frames_seen;
        drive(1'b0, 1'b1, pat_of(1), 50);
        drive(1'b1, 1'b0, pat_of(4), 3);
        drive(1'b1, 1'b1, BLANK, 20);
        check_bit("short_digit_no_frame", frames_seen == fc, 1'b1);
        check_state("short_digit_hold", model_now());

        // Alternating 12/13 never confirms, then a repeated 13 does.
        repeat (2) begin
            send_frame(pat_of(1), pat_of(2), 30, 30);
            send_frame(pat_of(1), pat_of(3), 30, 30);
        end
        repeat (2) send_frame(pat_of(1), pat_of(3), 30, 30);

        // 19 is out of range.
        repeat (2) send_frame(pat_of(1), pat_of(9), 30, 30);

        // Randomised groups of repeated frames, occasionally with corrupt segments.
        repeat (30) begin
            case ($urandom_range(0, 3))
                0: pt = BLANK;
                1: pt = pat_of(0);
                2: pt = pat_of(1);
                default: pt = pat_of(2);
            endcase
            pu = pat_of(int'($urandom_range(0, 9)));
            if ($urandom_range(0, 11) == 0) pt = bad_pats[$urandom_range(0, 3)];
            if ($urandom_range(0, 11) == 0) pu = bad_pats[$urandom_range(0, 3)];
            reps = int'($urandom_range(1, 3));
            repeat (reps) send_frame(pt, pu, int'($urandom_range(8, 30)), int'($urandom_range(8, 30)));
        end

        // Confirm 05, then stop scanning across the timeout boundary.
        repeat (2) send_frame(pat_of(0), pat_of(5), 30, 30);
        drive(1'b1, 1'b1, BLANK, 980);
        check_state("pre_timeout", model_now());
        drive(1'b1, 1'b1, BLANK, 70);
        m_valid = 0;
        match = 0;
        check_state("post_timeout", model_now());
        repeat (2) send_frame(pat_of(0), pat_of(5), 30, 30);

        // Reset in the middle of a frame.
        drive(1'b0, 1'b1, pat_of(1), 40);
        drive(1'b1, 1'b0, pat_of(5), 5);
        rst = 1'b1;
        an3_in = 1'b1; an4_in = 1'b1; seg_in = BLANK;
        @(negedge clk);
        model_reset();
        check_state("midframe_reset", model_now());
        check_bit("midframe_reset_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, BLANK, 4);
        repeat (2) send_frame(pat_of(0), pat_of(5), 30, 30);

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_bit("queue_drained", exp_q.size() == 0, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
